// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared JTAG definitions for the DR-side logic:
//   - tap_state_e : IEEE 1149.1 TAP controller state encoding
//   - INSN_*      : instruction register opcodes
//   - dr_sel_e    : data register selected for the current scan
//   - SR_W/LEN_W  : shift register width and width of a DR length value
// -----------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [3:0] INSN_IDCODE   = 4'h1;
    localparam logic [3:0] INSN_USERDATA = 4'h2;
    localparam logic [3:0] INSN_STATUS   = 4'h3;
    localparam logic [3:0] INSN_BYPASS   = 4'hF;

    typedef enum logic [1:0] {
        DR_BYPASS   = 2'd0,
        DR_IDCODE   = 2'd1,
        DR_USERDATA = 2'd2,
        DR_STATUS   = 2'd3
    } dr_sel_e;

    localparam int SR_W     = 32;
    localparam int LEN_W    = 6;
    localparam int STATUS_W = 8;

endpackage

// File: rtl/jtag_dr_decode.sv
// -----------------------------------------------------------------------------
// jtag_dr_decode
// Combinational instruction decode: maps the instruction register value to the
// data register it selects and that register's length in bits.
//   insn   : current instruction register value
//   sel_s  : selected data register
//   len_s  : length of the selected register (1..32)
// Macro JTAG_DR_STATUS_EN enables the STATUS instruction; without it 0x3
// falls through to BYPASS like every other unknown code.
// -----------------------------------------------------------------------------
module jtag_dr_decode
    import jtag_pkg::*;
#(
    parameter int USER_W = 8
) (
    input  logic [3:0]       insn,
    output dr_sel_e          sel_s,
    output logic [LEN_W-1:0] len_s
);

    // Opcode to register/length lookup; unknown opcodes select BYPASS.
    always_comb begin
        sel_s = DR_BYPASS;
        len_s = LEN_W'(1);
        case (insn)
            INSN_IDCODE: begin
                sel_s = DR_IDCODE;
                len_s = LEN_W'(SR_W);
            end
            INSN_USERDATA: begin
                sel_s = DR_USERDATA;
                len_s = LEN_W'(USER_W);
            end
`ifdef JTAG_DR_STATUS_EN
            INSN_STATUS: begin
                sel_s = DR_STATUS;
                len_s = LEN_W'(STATUS_W);
            end
`endif
            default: begin
                sel_s = DR_BYPASS;
                len_s = LEN_W'(1);
            end
        endcase
    end

endmodule

// File: rtl/jtag_dr_controller.sv
// -----------------------------------------------------------------------------
// jtag_dr_controller
// Data-register side of a JTAG TAP: captures, shifts and updates the IDCODE,
// USERDATA, STATUS and BYPASS registers through one shared 32-bit shift
// register whose active length follows the register latched at CAPTURE_DR.
//   TCK        : the only clock, rising edge
//   rst        : synchronous active-low reset
//   state      : current TAP state (jtag_pkg::tap_state_e encoding)
//   insn       : current instruction register value
//   TDI        : serial data in
//   tdo_o      : serial data out, valid while in SHIFT_DR
//   tdo_oe_o   : high while tdo_o is valid
//   user_o     : user data register
//   user_upd_o : one-cycle pulse after user_o is written
// Macro JTAG_DR_STATUS_EN builds the STATUS register and its update counter.
// -----------------------------------------------------------------------------
module jtag_dr_controller
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int          USER_W       = 8
) (
    input  logic              TCK,
    input  logic              rst,
    input  logic [3:0]        state,
    input  logic [3:0]        insn,
    input  logic              TDI,
    output logic              tdo_o,
    output logic              tdo_oe_o,
    output logic [USER_W-1:0] user_o,
    output logic              user_upd_o
);

    tap_state_e        st_s;
    dr_sel_e           dec_sel_s;
    logic [LEN_W-1:0]  dec_len_s;
    logic [SR_W-1:0]   cap_s;
    logic [SR_W-1:0]   sh_s;
    logic [4:0]        sh_idx_s;

    logic [SR_W-1:0]   sr_r;
    dr_sel_e           sel_r;
    logic [LEN_W-1:0]  len_r;
    logic [USER_W-1:0] user_r;
    logic              upd_r;
`ifdef JTAG_DR_STATUS_EN
    logic [3:0]        upd_cnt_r;
`endif

    assign st_s = tap_state_e'(state);

    jtag_dr_decode #(
        .USER_W (USER_W)
    ) u_decode (
        .insn  (insn),
        .sel_s (dec_sel_s),
        .len_s (dec_len_s)
    );

    // Capture value for the register being selected on this CAPTURE_DR edge.
    always_comb begin
        cap_s = '0;
        case (dec_sel_s)
            DR_IDCODE:   cap_s = IDCODE_VALUE;
            DR_USERDATA: cap_s[USER_W-1:0] = user_r;
`ifdef JTAG_DR_STATUS_EN
            DR_STATUS:   cap_s[STATUS_W-1:0] = {upd_cnt_r, insn};
`endif
            default:     cap_s = '0;
        endcase
    end

    // Right shift with TDI entering the top bit of the active register; the
    // captured value never sets bits at or above the length, so they stay 0.
    always_comb begin
        sh_idx_s         = 5'(len_r - LEN_W'(1));
        sh_s             = sr_r >> 1;
        sh_s[sh_idx_s]   = TDI;
    end

    // Serial output is only driven in SHIFT_DR.
    always_comb begin
        if (st_s == SH_DR) begin
            tdo_o    = sr_r[0];
            tdo_oe_o = 1'b1;
        end else begin
            tdo_o    = 1'b0;
            tdo_oe_o = 1'b0;
        end
    end

    // DR state: capture/shift/update actions keyed on the TAP state.
    always_ff @(posedge TCK) begin
        if (!rst) begin
            sr_r      <= '0;
            sel_r     <= DR_BYPASS;
            len_r     <= LEN_W'(1);
            user_r    <= '0;
            upd_r     <= 1'b0;
`ifdef JTAG_DR_STATUS_EN
            upd_cnt_r <= 4'd0;
`endif
        end else begin
            upd_r <= 1'b0;
            case (st_s)
                TLR: begin
                    user_r <= '0;
                    sel_r  <= DR_BYPASS;
                    len_r  <= LEN_W'(1);
                end
                CAP_DR: begin
                    sr_r  <= cap_s;
                    sel_r <= dec_sel_s;
                    len_r <= dec_len_s;
                end
                SH_DR: begin
                    sr_r <= sh_s;
                end
                UPD_DR: begin
                    if (sel_r == DR_USERDATA) begin
                        user_r    <= sr_r[USER_W-1:0];
                        upd_r     <= 1'b1;
`ifdef JTAG_DR_STATUS_EN
                        upd_cnt_r <= upd_cnt_r + 4'd1;
`endif
                    end
                end
                default: begin
                    // Pause/exit and all IR-side states hold everything.
                end
            endcase
        end
    end

    assign user_o     = user_r;
    assign user_upd_o = upd_r;

endmodule

// File: tb/tb_jtag_dr_controller.sv
module tb_jtag_dr_controller;

    localparam logic [3:0] S_TLR    = 4'hF;
    localparam logic [3:0] S_RTI    = 4'hC;
    localparam logic [3:0] S_SEL_DR = 4'h7;
    localparam logic [3:0] S_CAP_DR = 4'h6;
    localparam logic [3:0] S_SH_DR  = 4'h2;
    localparam logic [3:0] S_EX1_DR = 4'h1;
    localparam logic [3:0] S_PA_DR  = 4'h3;
    localparam logic [3:0] S_EX2_DR = 4'h0;
    localparam logic [3:0] S_UPD_DR = 4'h5;
    localparam logic [3:0] S_SEL_IR = 4'h4;
    localparam logic [3:0] S_CAP_IR = 4'hE;
    localparam logic [3:0] S_SH_IR  = 4'hA;
    localparam logic [3:0] S_EX1_IR = 4'h9;
    localparam logic [3:0] S_UPD_IR = 4'hD;

    logic       TCK = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] state = 4'hF;
    logic [3:0] insn = 4'h0;
    logic       TDI = 1'b0;
    logic       tdo_o;
    logic       tdo_oe_o;
    logic [7:0] user_o;
    logic       user_upd_o;

    int checks   = 0;
    int failures = 0;
    bit expq[$];

    jtag_dr_controller #(
        .IDCODE_VALUE (32'h1000_0001),
        .USER_W       (8)
    ) dut (
        .TCK        (TCK),
        .rst        (rst),
        .state      (state),
        .insn       (insn),
        .TDI        (TDI),
        .tdo_o      (tdo_o),
        .tdo_oe_o   (tdo_oe_o),
        .user_o     (user_o),
        .user_upd_o (user_upd_o)
    );

    always #5 TCK = ~TCK;

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic drive(input logic [3:0] st);
        state = st;
        tick();
    endtask

    // Present one SHIFT_DR cycle's inputs and let combinational outputs settle.
    task automatic shift_setup(input logic b);
        state = S_SH_DR;
        TDI   = b;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        bit e;
        v = 8'hA5;
        rst = 1'b0; state = S_TLR; insn = 4'h0; TDI = 1'b0;
        tick(); tick();
        checks++; if (user_o !== 8'h00) begin failures++; $display("FAIL reset_user got %h expected 00", user_o); end
        checks++; if (user_upd_o !== 1'b0) begin failures++; $display("FAIL reset_upd got %b expected 0", user_upd_o); end
        checks++; if (tdo_oe_o !== 1'b0) begin failures++; $display("FAIL reset_oe got %b expected 0", tdo_oe_o); end
        checks++; if (dut.sr_r !== 32'h0) begin failures++; $display("FAIL reset_sr got %h expected 0", dut.sr_r); end
        // Load 0xA5, then reset in the middle of a shift.
        rst = 1'b1; insn = 4'h2;
        drive(S_RTI); drive(S_CAP_DR);
        for (int i = 0; i < 8; i++) begin shift_setup(v[i]); tick(); end
        drive(S_EX1_DR); drive(S_UPD_DR);
        checks++; if (user_o !== 8'hA5) begin failures++; $display("FAIL reset_preload got %h expected a5", user_o); end
        drive(S_RTI); drive(S_CAP_DR);
        shift_setup(1'b1); tick();
        rst = 1'b0; tick(); tick();
        checks++; if (user_o !== 8'h00) begin failures++; $display("FAIL midscan_user got %h expected 00", user_o); end
        checks++; if (dut.sr_r !== 32'h0) begin failures++; $display("FAIL midscan_sr got %h expected 0", dut.sr_r); end
        checks++; if (user_upd_o !== 1'b0) begin failures++; $display("FAIL midscan_upd got %b expected 0", user_upd_o); end
        e = 1'b1;
        checks++; if (tdo_oe_o !== e) begin failures++; $display("FAIL midscan_oe got %b expected 1", tdo_oe_o); end
        rst = 1'b1;
        drive(S_RTI);
    endtask

    task automatic test_userdata();
        logic [7:0] v; logic [7:0] w; logic [7:0] c;
        bit e;
        v = 8'h3C; w = 8'hA5; c = 8'h5A;
        insn = 4'h2;
        drive(S_CAP_DR);
        for (int i = 0; i < 8; i++) expq.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            shift_setup(v[i]);
            e = expq.pop_front();
            checks++; if (tdo_o !== e || tdo_oe_o !== 1'b1) begin failures++; $display("FAIL user_tdo0 bit %0d got %b/%b expected %b/1", i, tdo_o, tdo_oe_o, e); end
            tick();
        end
        state = S_EX1_DR; #1;
        checks++; if (tdo_oe_o !== 1'b0) begin failures++; $display("FAIL user_oe_exit got %b expected 0", tdo_oe_o); end
        tick();
        drive(S_UPD_DR);
        checks++; if (user_o !== 8'h3C) begin failures++; $display("FAIL user_upd_val got %h expected 3c", user_o); end
        checks++; if (user_upd_o !== 1'b1) begin failures++; $display("FAIL user_upd_pulse got %b expected 1", user_upd_o); end
        drive(S_RTI);
        checks++; if (user_upd_o !== 1'b0) begin failures++; $display("FAIL user_upd_single got %b expected 0", user_upd_o); end
        // Second scan; insn changes mid-scan and must not alter the length.
        drive(S_CAP_DR);
        insn = 4'h1;
        for (int i = 0; i < 8; i++) expq.push_back(v[i]);
        for (int i = 0; i < 8; i++) expq.push_back(w[i]);
        for (int i = 0; i < 16; i++) begin
            shift_setup(i < 8 ? w[i] : c[i-8]);
            e = expq.pop_front();
            checks++; if (tdo_o !== e) begin failures++; $display("FAIL user_tdo1 bit %0d got %b expected %b", i, tdo_o, e); end
            tick();
        end
        drive(S_EX1_DR); drive(S_UPD_DR);
        checks++; if (user_o !== 8'h5A) begin failures++; $display("FAIL user_upd2 got %h expected 5a", user_o); end
        insn = 4'h2;
        drive(S_RTI);
    endtask

    task automatic test_idcode();
        logic [31:0] id;
        int oe_cnt;
        bit e;
        id = 32'h1000_0001; oe_cnt = 0;
        insn = 4'h1;
        state = S_CAP_DR; #1;
        checks++; if (tdo_oe_o !== 1'b0) begin failures++; $display("FAIL id_oe_cap got %b expected 0", tdo_oe_o); end
        tick();
        for (int i = 0; i < 32; i++) expq.push_back(id[i]);
        for (int i = 0; i < 32; i++) begin
            shift_setup(1'b0);
            if (tdo_oe_o === 1'b1) oe_cnt++;
            e = expq.pop_front();
            checks++; if (tdo_o !== e) begin failures++; $display("FAIL id_tdo bit %0d got %b expected %b", i, tdo_o, e); end
            tick();
        end
        state = S_EX1_DR; #1;
        if (tdo_oe_o === 1'b1) oe_cnt++;
        checks++; if (oe_cnt !== 32) begin failures++; $display("FAIL id_oe_count got %0d expected 32", oe_cnt); end
        tick();
        drive(S_UPD_DR);
        checks++; if (user_o !== 8'h5A || user_upd_o !== 1'b0) begin failures++; $display("FAIL id_upd got %h/%b expected 5a/0", user_o, user_upd_o); end
        drive(S_RTI);
    endtask

    task automatic test_bypass();
        logic [3:0] p; logic [3:0] q;
        bit e;
        p = 4'b1101; q = 4'b1010;   // TDI 1,0,1,1 -> tdo 0,1,0,1
        insn = 4'h7;
        drive(S_CAP_DR);
        for (int i = 0; i < 4; i++) expq.push_back(q[i]);
        for (int i = 0; i < 4; i++) begin
            shift_setup(p[i]);
            e = expq.pop_front();
            checks++; if (tdo_o !== e) begin failures++; $display("FAIL bypass_tdo bit %0d got %b expected %b", i, tdo_o, e); end
            tick();
        end
        drive(S_EX1_DR); drive(S_UPD_DR);
        checks++; if (user_o !== 8'h5A || user_upd_o !== 1'b0) begin failures++; $display("FAIL bypass_upd got %h/%b expected 5a/0", user_o, user_upd_o); end
        drive(S_RTI);
    endtask

    task automatic test_pause();
        logic [7:0] v; logic [7:0] old;
        bit e;
        v = 8'h96; old = 8'h5A;
        insn = 4'h2;
        drive(S_CAP_DR);
        for (int i = 0; i < 8; i++) expq.push_back(old[i]);
        for (int i = 0; i < 4; i++) begin
            shift_setup(v[i]);
            e = expq.pop_front();
            checks++; if (tdo_o !== e) begin failures++; $display("FAIL pause_tdo_a bit %0d got %b expected %b", i, tdo_o, e); end
            tick();
        end
        drive(S_EX1_DR); drive(S_PA_DR); drive(S_PA_DR); drive(S_PA_DR); drive(S_EX2_DR);
        for (int i = 4; i < 8; i++) begin
            shift_setup(v[i]);
            e = expq.pop_front();
            checks++; if (tdo_o !== e) begin failures++; $display("FAIL pause_tdo_b bit %0d got %b expected %b", i, tdo_o, e); end
            tick();
        end
        drive(S_EX1_DR); drive(S_UPD_DR);
        checks++; if (user_o !== 8'h96) begin failures++; $display("FAIL pause_user got %h expected 96", user_o); end
        drive(S_RTI);
    endtask

    task automatic test_ir_and_tlr();
        logic [7:0] v;
        v = 8'hC3;
        insn = 4'h2;
        drive(S_CAP_DR);
        for (int i = 0; i < 8; i++) begin shift_setup(v[i]); tick(); end
        drive(S_EX1_DR); drive(S_SEL_DR); drive(S_SEL_IR); drive(S_CAP_IR);
        drive(S_SH_IR); drive(S_EX1_IR); drive(S_UPD_IR); drive(S_RTI);
        checks++; if (user_o !== 8'h96) begin failures++; $display("FAIL ir_hold_user got %h expected 96", user_o); end
        drive(S_UPD_DR);
        checks++; if (user_o !== 8'hC3) begin failures++; $display("FAIL ir_hold_sr got %h expected c3", user_o); end
        drive(S_RTI);
        drive(S_TLR);
        checks++; if (user_o !== 8'h00 || user_upd_o !== 1'b0) begin failures++; $display("FAIL tlr_user got %h/%b expected 00/0", user_o, user_upd_o); end
        drive(S_RTI);
        drive(S_UPD_DR);
        checks++; if (user_o !== 8'h00 || user_upd_o !== 1'b0) begin failures++; $display("FAIL tlr_sel got %h/%b expected 00/0", user_o, user_upd_o); end
        drive(S_RTI);
    endtask

    task automatic test_status();
        logic [7:0] cap;
        bit e;
        rst = 1'b0; tick(); rst = 1'b1;
        insn = 4'h2;
        for (int n = 0; n < 17; n++) begin
            drive(S_CAP_DR); drive(S_UPD_DR); drive(S_RTI);
        end
        insn = 4'h3;
        drive(S_CAP_DR);
`ifdef JTAG_DR_STATUS_EN
        cap = 8'h13;
        for (int i = 0; i < 8; i++) expq.push_back(cap[i]);
`else
        cap = 8'hFE;   // BYPASS with TDI held 1: one 0, then ones
        for (int i = 0; i < 8; i++) expq.push_back(cap[i]);
`endif
        for (int i = 0; i < 8; i++) begin
            shift_setup(1'b1);
            e = expq.pop_front();
            checks++; if (tdo_o !== e) begin failures++; $display("FAIL status_tdo bit %0d got %b expected %b", i, tdo_o, e); end
            tick();
        end
        drive(S_EX1_DR); drive(S_RTI);
    endtask

    initial begin
        test_reset();
        test_userdata();
        test_idcode();
        test_bypass();
        test_pause();
        test_ir_and_tlr();
        test_status();
        checks++; if (expq.size() !== 0) begin failures++; $display("FAIL scoreboard_left got %0d expected 0", expq.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_dr_controller.md
JTAG_DR_CONTROLLER -- requirements
Module: jtag_dr_controller

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h1000_0001, is the 32-bit device ID returned by IDCODE; bit 0 SHALL be 1.
REQ-002 Parameter USER_W, default 8, is the width of the user data register, legal range 2..32.
REQ-003 Port TCK, input, 1: the only clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port state, input, 4: current TAP state, IEEE 1149.1 encoding from the package.
REQ-006 Port insn, input, 4: current instruction register value.
REQ-007 Port TDI, input, 1: serial data in.
REQ-008 Port tdo_o, output, 1: DR serial data out.
REQ-009 Port tdo_oe_o, output, 1: high while tdo_o is valid.
REQ-010 Port user_o, output, USER_W: user data register contents.
REQ-011 Port user_upd_o, output, 1: single-cycle pulse when user_o is written.

Function
REQ-012 Instruction decode SHALL be: 0x1 IDCODE (32-bit), 0x2 USERDATA (USER_W), 0x3 STATUS (8-bit, see REQ-021); all other codes, including 0xF, select BYPASS (1-bit).
REQ-013 The DR select register (sel) SHALL latch the decoded insn on the rising edge where state==CAPTURE_DR, and hold it until the next CAPTURE_DR; insn changes at other times SHALL NOT affect an ongoing scan.
REQ-014 In CAPTURE_DR, the 32-bit shift register (sr) SHALL load the capture value: IDCODE_VALUE; the current user_o (zero-extended); the status byte; or 0 for BYPASS.
REQ-015 In SHIFT_DR, sr SHALL shift right by one bit, with TDI entering bit L-1, where L is the length of the selected register; bits at L and above SHALL stay 0.
REQ-016 tdo_o SHALL equal sr[0] and tdo_oe_o SHALL be 1 exactly while state==SHIFT_DR; otherwise both SHALL be 0 (combinational from state and sr).
REQ-017 With sel==USERDATA, on the edge where state==UPDATE_DR, user_o SHALL take sr[USER_W-1:0] and user_upd_o SHALL be 1 for the following cycle only.
REQ-018 UPDATE_DR with any other selection SHALL leave user_o unchanged and produce no pulse.
REQ-019 PAUSE_DR and EXIT1/EXIT2_DR SHALL hold sr; a re-entry to SHIFT_DR SHALL resume shifting from the held value.
REQ-020 When state==TEST_LOGIC_RESET: user_o SHALL go to 0 and sel to BYPASS, with no upd pulse.
REQ-021 The status byte SHALL be {upd_cnt[3:0], insn[3:0]}, where upd_cnt counts USERDATA updates and wraps 15->0.
REQ-022 IR-side states (SELECT_IR..UPDATE_IR) SHALL leave all registers unchanged.

Reset
REQ-023 While rst==0 at a rising TCK, the following SHALL apply, overriding every state-driven action including a mid-scan: sr=0, sel=BYPASS, user_o=0, user_upd_o=0, upd_cnt=0; tdo_o and tdo_oe_o then follow REQ-016.

Configuration
REQ-024 With JTAG_DR_STATUS_EN defined, the STATUS instruction and upd_cnt SHALL exist.
REQ-025 Without JTAG_DR_STATUS_EN, 0x3 SHALL decode to BYPASS and upd_cnt SHALL not be built.

Structure
REQ-026 The shared package jtag_pkg SHALL hold the TAP state enum (TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UPD_IR=D), the instruction opcode constants, and the DR select enum.
REQ-027 One sub-module, jtag_dr_decode, SHALL be combinational and map insn to a DR select value and a length, honouring JTAG_DR_STATUS_EN.

Verification
REQ-028 Reset: hold rst=0 for 2 cycles during SHIFT_DR with user_o=0xA5 -> user_o=0, sr=0, no upd pulse.
REQ-029 IDCODE: insn=0x1, CAP_DR, then 32 SH_DR cycles -> tdo_o sequence LSB-first = 0x10000001, with tdo_oe_o=1 on exactly those 32 cycles.
REQ-030 USERDATA: insn=0x2, shift TDI=0x3C LSB-first over 8 cycles, then UPD_DR -> user_o=0x3C, user_upd_o high for one cycle; a second scan captures and shifts out 0x3C.
REQ-031 BYPASS: insn=0x7, shift TDI pattern 1,0,1,1 -> tdo_o = 0,1,0,1 (one-cycle delay).
REQ-032 Pause: USERDATA scan with 4 shifts, 3 PA_DR cycles, then 4 more shifts and UPD_DR -> same user_o as an unpaused 8-shift scan.
REQ-033 STATUS (macro on): 17 USERDATA updates, then insn=0x3 scan -> captured byte 0x13; with the macro off, the same scan behaves as BYPASS.
